// File: rtl/crypto_pkg.sv
// Shared definitions for the 8-bit cryptosystem datapath.
// Holds the select encodings and the default byte-wide datapath width.
package crypto_pkg;

    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;
    localparam int   DATA_W = 8;

endpackage

// File: rtl/mux_2to1.sv
// 2:1 selection primitive: combinational y for same-cycle steering, y_q as a retimed copy.
// No enable and no handshake: y_q simply follows y one clock later.
module mux_2to1
    import crypto_pkg::*;
#(
    parameter int          WIDTH     = 1,
    parameter logic [63:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    generate
        if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
            $fatal(1, "mux_2to1: WIDTH must be in 1..64");
        end
    endgenerate

    localparam logic [WIDTH-1:0] RST_Y = RESET_VAL[WIDTH-1:0];

    // The a&b consensus term keeps bits where a and b agree defined even when
    // sel is X/Z; the remaining bits go X instead of silently picking a.
    function automatic logic [WIDTH-1:0] pick(input logic             s,
                                              input logic [WIDTH-1:0] da,
                                              input logic [WIDTH-1:0] db);
        logic [WIDTH-1:0] m;
        m    = {WIDTH{s == SEL_B}};
        pick = (da & db) | (da & ~m) | (db & m);
    endfunction

    assign y = pick(sel, a, b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= RST_Y;
        end else begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1 at 1-bit and byte width against a simple select model.
module tb_mux_2to1;

    logic       clk;
    logic       rst;
    logic       a1, b1, sel1, y1, yq1;
    logic [7:0] a8, b8, y8, yq8;
    logic       sel8;

    int tests_run;
    int tests_failed;

    logic [7:0] exp_q[$];

    mux_2to1 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .sel(sel1), .y(y1), .y_q(yq1)
    );

    mux_2to1 #(.WIDTH(8), .RESET_VAL(64'h5A)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .sel(sel8), .y(y8), .y_q(yq8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] model_y(input logic s, input logic [7:0] da,
                                           input logic [7:0] db);
        return s ? db : da;
    endfunction

    task automatic test_reset();
        rst = 1'b1; a1 = 0; b1 = 0; sel1 = 0; a8 = 8'h00; b8 = 8'h00; sel8 = 0;
        #1;
        tests_run++;
        if (yq8 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL reset_yq8: got %h, required 5a", yq8);
        end
        tests_run++;
        if (yq1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_yq1: got %b, required 0", yq1);
        end
        @(posedge clk); #1;
        tests_run++;
        if (yq8 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL reset_hold_yq8: got %h, required 5a", yq8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic exp_prev;
        for (int s = 0; s < 2; s++) begin
            for (int ab = 0; ab < 4; ab++) begin
                @(negedge clk);
                a1   = ab[1];
                b1   = ab[0];
                sel1 = s[0];
                #1;
                exp_prev = s[0] ? ab[0] : ab[1];
                tests_run++;
                if (y1 !== exp_prev) begin
                    tests_failed++;
                    $display("FAIL tt_y a=%b b=%b sel=%b: got %b, required %b",
                             a1, b1, sel1, y1, exp_prev);
                end
                @(posedge clk); #1;
                tests_run++;
                if (yq1 !== exp_prev) begin
                    tests_failed++;
                    $display("FAIL tt_yq: got %b, required %b", yq1, exp_prev);
                end
            end
        end
    endtask

    task automatic test_byte();
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            a8 = 8'hA5; b8 = 8'h3C; sel8 = s[0];
            #1;
            tests_run++;
            if (y8 !== (s[0] ? 8'h3C : 8'hA5)) begin
                tests_failed++;
                $display("FAIL byte_y sel=%0d: got %h, required %h", s, y8,
                         s[0] ? 8'h3C : 8'hA5);
            end
            @(posedge clk); #1;
            tests_run++;
            if (yq8 !== (s[0] ? 8'h3C : 8'hA5)) begin
                tests_failed++;
                $display("FAIL byte_yq sel=%0d: got %h, required %h", s, yq8,
                         s[0] ? 8'h3C : 8'hA5);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (yq8 !== 8'h3C) begin
            tests_failed++;
            $display("FAIL arst_pre_yq: got %h, required 3c", yq8);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (yq8 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL arst_immediate_yq: got %h, required 5a", yq8);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (yq8 !== 8'h5A) begin
                tests_failed++;
                $display("FAIL arst_hold_yq cycle %0d: got %h, required 5a", i, yq8);
            end
            tests_run++;
            if (y8 !== 8'h3C) begin
                tests_failed++;
                $display("FAIL arst_y_unaffected: got %h, required 3c", y8);
            end
        end
        @(negedge clk);
        sel8 = 1'b0; a8 = 8'h11; rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (yq8 !== 8'h11) begin
            tests_failed++;
            $display("FAIL arst_release_yq: got %h, required 11", yq8);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        logic       s;
        exp_q.delete();
        s = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a8 = 8'h00; b8 = 8'hFF; sel8 = s;
            #1;
            e = s ? 8'hFF : 8'h00;
            tests_run++;
            if (y8 !== e) begin
                tests_failed++;
                $display("FAIL toggle_y cycle %0d: got %h, required %h", i, y8, e);
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if (yq8 !== e) begin
                tests_failed++;
                $display("FAIL toggle_yq cycle %0d: got %h, required %h", i, yq8, e);
            end
            s = ~s;
        end
    endtask

    task automatic test_equal_inputs();
        logic [7:0] agree;
        @(negedge clk);
        a8 = 8'h77; b8 = 8'h77; sel8 = 1'bx;
        #1;
        tests_run++;
        if (y8 !== 8'h77) begin
            tests_failed++;
            $display("FAIL equal_y_selx: got %h, required 77", y8);
        end
        b8 = 8'h78;
        #1;
        agree = ~(a8 ^ b8);
        tests_run++;
        if ((y8 & agree) !== (a8 & agree)) begin
            tests_failed++;
            $display("FAIL equal_agree_bits_selx: got %h, required %h",
                     y8 & agree, a8 & agree);
        end
        @(negedge clk);
        sel8 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] e;
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a8   = 8'($urandom_range(0, 255));
            b8   = 8'($urandom_range(0, 255));
            sel8 = 1'($urandom_range(0, 1));
            #1;
            e = model_y(sel8, a8, b8);
            tests_run++;
            if (y8 !== e) begin
                tests_failed++;
                $display("FAIL rand_y iter %0d: got %h, required %h", i, y8, e);
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            tests_run++;
            if (yq8 !== e) begin
                tests_failed++;
                $display("FAIL rand_yq iter %0d: got %h, required %h", i, yq8, e);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_truth_table();
        test_byte();
        test_async_reset();
        test_back_to_back();
        test_equal_inputs();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
